mult_scheduler: RTL and testbench

Arbitrates the shared 8-bit signed add-shift multiplier datapath (A/B/X register unit plus adder) between two requesters. It sequences one full multiply per grant: load operands, run 8 add/subtract-then-shift steps, then capture the 16-bit product. It replaces the button-driven run sequencing, so software-style requesters can share one multiplier, and sits between the requesters and the register unit/adder.

---
 rtl/mult_sched_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/mult_scheduler.sv | 126 ++++++++++++
 tb/tb_mult_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the add-shift multiplier scheduler.
package mult_sched_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef logic req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; favours the requester not served last.
module rr_arbiter2
    import mult_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  req_idx_t   served,
    output logic [1:0] grant,
    output req_idx_t   winner
);

    req_idx_t last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= served;
        end
    end

    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
        if (req != 2'b00) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Sequences one full signed add-shift multiply per grant on a shared datapath.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [1:0]                  Req,
    input  logic signed [WIDTH-1:0]     Mcand0,
    input  logic signed [WIDTH-1:0]     Mcand1,
    input  logic signed [WIDTH-1:0]     Mplier0,
    input  logic signed [WIDTH-1:0]     Mplier1,
    output logic [1:0]                  Grant,
    output logic [1:0]                  Done,
    output logic signed [2*WIDTH-1:0]   Product,
    output logic                        Busy,
    output logic                        LoadB,
    output logic                        ClearA,
    output logic                        Add,
    output logic                        Sub,
    output logic                        Shift,
    output logic signed [WIDTH-1:0]     Din,
    input  logic                        M,
    input  logic [WIDTH-1:0]            Aval,
    input  logic [WIDTH-1:0]            Bval
);

    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WIDTH - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          k_q;
    req_idx_t                  winner_q;
    logic signed [WIDTH-1:0]   mcand_q;
    logic signed [2*WIDTH-1:0] product_q;
    logic [1:0]                arb_grant;
    req_idx_t                  arb_winner;
    logic                      advance;
    logic [1:0]                winner_onehot;

    rr_arbiter2 u_arb (
        .clk     (Clk),
        .rst     (Reset),
        .req     (Req),
        .advance (advance),
        .served  (winner_q),
        .grant   (arb_grant),
        .winner  (arb_winner)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            winner_q  <= 1'b0;
            product_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && arb_grant != 2'b00) begin
                winner_q <= arb_winner;
            end
            if (state_q == ST_LOAD) begin
                k_q <= '0;
            end else if (state_q == ST_SHIFT && k_q != LAST_K) begin
                k_q <= k_q + 1'b1;
            end
            if (state_q == ST_DONE) begin
                product_q <= {Aval, Bval};
            end
        end
    end

    // Multiplicand is held locally so requesters may change it once LOAD is over.
    always_ff @(posedge Clk) begin
        if (state_q == ST_LOAD) begin
            mcand_q <= winner_q ? Mcand1 : Mcand0;
        end
    end

    always_comb begin
        state_d = state_q;
        LoadB   = 1'b0;
        ClearA  = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Din     = '0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_grant != 2'b00) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                Din     = winner_q ? Mplier1 : Mplier0;
                LoadB   = 1'b1;
                ClearA  = 1'b1;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                // The final step subtracts: the multiplier's MSB carries negative weight.
                Din = mcand_q;
                if (M) begin
                    if (k_q == LAST_K) Sub = 1'b1;
                    else               Add = 1'b1;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                Shift   = 1'b1;
                state_d = (k_q == LAST_K) ? ST_DONE : ST_ADD;
            end
            ST_DONE: begin
                advance = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign winner_onehot = winner_q ? 2'b10 : 2'b01;
    assign Busy          = (state_q != ST_IDLE);
    assign Grant         = Busy ? winner_onehot : 2'b00;
    assign Done          = (state_q == ST_DONE) ? winner_onehot : 2'b00;
    assign Product       = (state_q == ST_DONE) ? $signed({Aval, Bval}) : product_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler with a behavioural A/B/X register unit and adder.
module tb_mult_scheduler;

    logic               Clk = 1'b0;
    logic               Reset;
    logic [1:0]         Req;
    logic signed [7:0]  Mcand0, Mcand1, Mplier0, Mplier1;
    logic [1:0]         Grant, Done;
    logic signed [15:0] Product;
    logic               Busy, LoadB, ClearA, Add, Sub, Shift;
    logic signed [7:0]  Din;
    logic               M;
    logic [7:0]         Aval, Bval;

    int checks = 0;
    int errors = 0;
    int strobe_viol = 0;
    int add_cnt = 0;
    int sub_cnt = 0;

    typedef struct {
        logic [1:0]  done;
        logic [15:0] prod;
    } exp_t;
    exp_t exp_q[$];

    always #5 Clk = ~Clk;

    mult_scheduler #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req),
        .Mcand0(Mcand0), .Mcand1(Mcand1), .Mplier0(Mplier0), .Mplier1(Mplier1),
        .Grant(Grant), .Done(Done), .Product(Product), .Busy(Busy),
        .LoadB(LoadB), .ClearA(ClearA), .Add(Add), .Sub(Sub), .Shift(Shift),
        .Din(Din), .M(M), .Aval(Aval), .Bval(Bval)
    );

    // Register unit plus adder: {X,A} <= A +/- Din, then arithmetic shift of {X,A,B}.
    logic [7:0] a_r = 8'h00, b_r = 8'h00;
    logic       x_r = 1'b0;
    always_ff @(posedge Clk) begin
        if (ClearA) begin
            a_r <= 8'h00;
            x_r <= 1'b0;
        end else if (Add) begin
            {x_r, a_r} <= {a_r[7], a_r} + {Din[7], Din};
        end else if (Sub) begin
            {x_r, a_r} <= {a_r[7], a_r} - {Din[7], Din};
        end else if (Shift) begin
            a_r <= {x_r, a_r[7:1]};
        end
        if (LoadB)      b_r <= Din;
        else if (Shift) b_r <= {a_r[0], b_r[7:1]};
    end
    assign M    = b_r[0];
    assign Aval = a_r;
    assign Bval = b_r;

    // Scoreboard: every Done pops the oldest expected result.
    always @(negedge Clk) begin
        exp_t e;
        if ((int'(LoadB) + int'(Add) + int'(Sub) + int'(Shift)) > 1) strobe_viol++;
        if (Add) add_cnt++;
        if (Sub) sub_cnt++;
        if (Done != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done done=%b product=%h", Done, Product);
            end else begin
                e = exp_q.pop_front();
                if (Done !== e.done || Product !== e.prod) begin
                    errors++;
                    $display("FAIL scoreboard done=%b product=%h expected done=%b product=%h",
                             Done, Product, e.done, e.prod);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic exp_t make_exp(input int idx, input logic [7:0] mc, input logic [7:0] mp);
        exp_t e;
        logic signed [15:0] a16, b16;
        a16 = {{8{mc[7]}}, mc};
        b16 = {{8{mp[7]}}, mp};
        e.prod = a16 * b16;
        e.done = (idx == 1) ? 2'b10 : 2'b01;
        return e;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [7:0] mc, input logic [7:0] mp);
        if (idx == 1) begin Mcand1 = mc; Mplier1 = mp; end
        else          begin Mcand0 = mc; Mplier0 = mp; end
    endtask

    task automatic do_mult(input int idx, input logic [7:0] mc, input logic [7:0] mp);
        int n;
        logic [1:0] oh;
        oh = (idx == 1) ? 2'b10 : 2'b01;
        set_ops(idx, mc, mp);
        exp_q.push_back(make_exp(idx, mc, mp));
        Req[idx] = 1'b1;
        tick();
        n = 1;
        checks++;
        if (Grant !== oh || LoadB !== 1'b1 || ClearA !== 1'b1) begin
            errors++;
            $display("FAIL load_cycle grant=%b loadb=%b cleara=%b expected grant=%b loadb=1 cleara=1",
                     Grant, LoadB, ClearA, oh);
        end
        while (Done == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 18 || Grant !== oh) begin
            errors++;
            $display("FAIL done_latency cycles=%0d grant=%b expected cycles=18 grant=%b", n, Grant, oh);
        end
        Req[idx] = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0 || Grant !== 2'b00 || Done !== 2'b00) begin
            errors++;
            $display("FAIL return_idle busy=%b grant=%b done=%b expected 0 00 00", Busy, Grant, Done);
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Req = 2'b00;
        set_ops(0, 8'h00, 8'h00);
        set_ops(1, 8'h00, 8'h00);
        apply_reset();
        checks++;
        if ({Grant, Done, Busy, LoadB, ClearA, Add, Sub, Shift} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b expected=0", {Grant, Done, Busy, LoadB, ClearA, Add, Sub, Shift});
        end
        checks++;
        if (Din !== 8'h00 || Product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data din=%h product=%h expected 00 0000", Din, Product);
        end
        tick();
    endtask

    task automatic test_basic();
        do_mult(0, 8'h07, 8'h05);
        do_mult(1, 8'hFD, 8'h04);
        sub_cnt = 0;
        do_mult(1, 8'h05, 8'hFD);
        checks++;
        if (sub_cnt != 1) begin
            errors++;
            $display("FAIL sub_step count=%0d expected=1", sub_cnt);
        end
    endtask

    task automatic test_boundary();
        do_mult(0, 8'h80, 8'h80);
        add_cnt = 0;
        sub_cnt = 0;
        do_mult(0, 8'hFF, 8'h00);
        checks++;
        if (add_cnt + sub_cnt != 0) begin
            errors++;
            $display("FAIL zero_mplier add=%0d sub=%0d expected 0 0", add_cnt, sub_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        apply_reset();
        set_ops(0, 8'h0C, 8'hF6);
        set_ops(1, 8'h7F, 8'h7F);
        exp_q.push_back(make_exp(0, 8'h0C, 8'hF6));
        exp_q.push_back(make_exp(1, 8'h7F, 8'h7F));
        Req = 2'b11;
        tick();
        n = 1;
        checks++;
        if (Grant !== 2'b01) begin
            errors++;
            $display("FAIL b2b_first_grant grant=%b expected=01", Grant);
        end
        while (Done == 2'b00 && n < 40) begin tick(); n++; end
        checks++;
        if (n != 18 || Done !== 2'b01) begin
            errors++;
            $display("FAIL b2b_done0 cycles=%0d done=%b expected 18 01", n, Done);
        end
        Req[0] = 1'b0;
        tick(); n++;
        while (Done == 2'b00 && n < 60) begin tick(); n++; end
        checks++;
        if (n != 37 || Done !== 2'b10) begin
            errors++;
            $display("FAIL b2b_done1 cycles=%0d done=%b expected 37 10", n, Done);
        end
        Req = 2'b00;
        tick();
    endtask

    task automatic test_held_alternation();
        int n, last_n;
        int exp_next;
        exp_next = 0;
        set_ops(0, 8'h03, 8'h81);
        set_ops(1, 8'hC0, 8'h02);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_q.push_back(make_exp(0, 8'h03, 8'h81));
            else            exp_q.push_back(make_exp(1, 8'hC0, 8'h02));
        end
        Req = 2'b11;
        n = 0;
        last_n = -1;
        for (int i = 0; i < 4; i++) begin
            tick(); n++;
            while (Done == 2'b00 && n < 100) begin tick(); n++; end
            checks++;
            if (Done !== ((exp_next == 1) ? 2'b10 : 2'b01) ||
                n != ((last_n < 0) ? 18 : last_n + 19)) begin
                errors++;
                $display("FAIL held_order idx=%0d done=%b cycle=%0d expected_req=%0d", i, Done, n, exp_next);
            end
            last_n = n;
            exp_next = 1 - exp_next;
        end
        Req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int done_seen;
        set_ops(0, 8'h55, 8'h33);
        Req = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (Busy !== 1'b1 || Shift !== 1'b0 || Din !== 8'h55) begin
            errors++;
            $display("FAIL mid_add busy=%b shift=%b din=%h expected 1 0 55", Busy, Shift, Din);
        end
        Reset = 1'b1;
        Req = 2'b00;
        tick();
        Reset = 1'b0;
        checks++;
        if ({Grant, Done, Busy, LoadB, ClearA, Add, Sub, Shift} !== 10'b0 ||
            Din !== 8'h00 || Product !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset ctrl=%b din=%h product=%h expected all zero",
                     {Grant, Done, Busy, LoadB, ClearA, Add, Sub, Shift}, Din, Product);
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Done != 2'b00 || Busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL aborted_activity count=%0d expected=0", done_seen);
        end
        do_mult(0, 8'hF9, 8'h09);
    endtask

    task automatic test_operand_change();
        int n;
        set_ops(0, 8'h0B, 8'h06);
        exp_q.push_back(make_exp(0, 8'h0B, 8'h06));
        Req = 2'b01;
        tick();
        tick();
        n = 2;
        set_ops(0, 8'h7F, 8'h13);
        while (Done == 2'b00 && n < 40) begin tick(); n++; end
        checks++;
        if (n != 18 || Product !== 16'h0042) begin
            errors++;
            $display("FAIL operand_hold cycles=%0d product=%h expected 18 0042", n, Product);
        end
        Req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_final();
        checks++;
        if (strobe_viol != 0) begin
            errors++;
            $display("FAIL strobe_onehot violations=%0d expected=0", strobe_viol);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results left=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        Reset = 1'b1;
        Req = 2'b00;
        Mcand0 = '0; Mcand1 = '0; Mplier0 = '0; Mplier1 = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_held_alternation();
        test_reset_mid();
        test_operand_change();
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
